// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types, opcodes and instruction field positions for the ALU sequencer
package alu_pkg;

    localparam int WIDTH = 8;
    localparam int NREGS = 4;

    typedef enum logic [2:0] {
        OP_OR    = 3'b000,
        OP_AND   = 3'b001,
        OP_XOR   = 3'b010,
        OP_NOTA  = 3'b011,
        OP_ADD   = 3'b100,
        OP_SUB   = 3'b101,
        OP_INCA  = 3'b110,
        OP_INCB  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        CL_ALU   = 2'b00,
        CL_LOADI = 2'b01,
        CL_OUT   = 2'b10,
        CL_NOP   = 2'b11
    } instr_class_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_EXEC     = 2'b01,
        S_OUT_WAIT = 2'b10
    } seq_state_e;

    localparam int CLASS_HI  = 15;
    localparam int CLASS_LO  = 14;
    localparam int OP_HI     = 13;
    localparam int OP_LO     = 11;
    localparam int RD_HI     = 10;
    localparam int RD_LO     = 9;
    localparam int RA_HI     = 8;
    localparam int RA_LO     = 7;
    localparam int RB_HI     = 6;
    localparam int RB_LO     = 5;
    localparam int LRD_HI    = 9;
    localparam int LRD_LO    = 8;
    localparam int IMM_HI    = 7;
    localparam int IMM_LO    = 0;
    localparam int SKIPZ_BIT = 13;

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - register file with two asynchronous read ports and one synchronous write port
module alu_regfile #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - instruction sequencer driving an external 8-bit ALU; optional ALU_SEQUENCER_FLAGS_EN adds zero flag and SKIPZ
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int NREGS = alu_pkg::NREGS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_x,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data
`ifdef ALU_SEQUENCER_FLAGS_EN
    ,
    output logic             zero
`endif
);

    localparam int AW = $clog2(NREGS);

    seq_state_e       state, state_nxt;
    instr_class_e     cls;
    alu_op_e          ir_op;
    logic [AW-1:0]    ir_rd, ir_ra, ir_rb;
    logic             accept, discard;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr, raddr_a;
    logic [WIDTH-1:0] rf_wdata, rdata_a, rdata_b;
    logic             unused_instr_bits;

    assign cls               = instr_class_e'(instr[CLASS_HI:CLASS_LO]);
    assign accept            = instr_valid & instr_ready;
    assign res_valid         = (state == S_OUT_WAIT);
    assign unused_instr_bits = ^instr[4:0];

`ifdef ALU_SEQUENCER_FLAGS_EN
    logic zero_q, skip_q, skipz_hit;
    assign discard   = skip_q;
    assign skipz_hit = (cls == CL_NOP) && instr[SKIPZ_BIT] && zero_q;
    assign zero      = zero_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            skip_q <= 1'b0;
        end else begin
            // A discarded instruction only consumes the pending skip, it never arms a new one
            if (accept) skip_q <= skip_q ? 1'b0 : skipz_hit;
            if (state == S_EXEC) zero_q <= (alu_x == '0);
        end
    end
`else
    assign discard = 1'b0;
`endif

    alu_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (ir_rb),
        .rdata_b (rdata_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = 3'b000;
        rf_we       = 1'b0;
        rf_waddr    = instr[LRD_HI:LRD_LO];
        rf_wdata    = instr[IMM_HI:IMM_LO];
        raddr_a     = instr[RA_HI:RA_LO];
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (accept && !discard) begin
                    case (cls)
                        CL_ALU:   state_nxt = S_EXEC;
                        CL_OUT:   state_nxt = S_OUT_WAIT;
                        CL_LOADI: rf_we     = 1'b1;
                        default:  state_nxt = S_IDLE;
                    endcase
                end
            end
            S_EXEC: begin
                raddr_a   = ir_ra;
                alu_a     = rdata_a;
                alu_b     = rdata_b;
                alu_op    = ir_op;
                rf_we     = 1'b1;
                rf_waddr  = ir_rd;
                rf_wdata  = alu_x;
                state_nxt = S_IDLE;
            end
            S_OUT_WAIT: begin
                if (res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // res_data is a snapshot taken at the OUT accept edge and held through OUT_WAIT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_op    <= OP_OR;
            ir_rd    <= '0;
            ir_ra    <= '0;
            ir_rb    <= '0;
            res_data <= '0;
        end else if (accept) begin
            ir_op <= alu_op_e'(instr[OP_HI:OP_LO]);
            ir_rd <= instr[RD_HI:RD_LO];
            ir_ra <= instr[RA_HI:RA_LO];
            ir_rb <= instr[RB_HI:RB_LO];
            if (!discard && cls == CL_OUT) res_data <= rdata_a;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed table-driven bench for alu_sequencer with an ALU reference
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = 16'h0;
    logic [7:0]  alu_a, alu_b, alu_x;
    logic [2:0]  alu_op;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_data;
`ifdef ALU_SEQUENCER_FLAGS_EN
    logic        zero;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_x       (alu_x),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data)
`ifdef ALU_SEQUENCER_FLAGS_EN
        ,
        .zero        (zero)
`endif
    );

    always_comb begin
        case (alu_op)
            3'b000:  alu_x = alu_a | alu_b;
            3'b001:  alu_x = alu_a & alu_b;
            3'b010:  alu_x = alu_a ^ alu_b;
            3'b011:  alu_x = ~alu_a;
            3'b100:  alu_x = alu_a + alu_b;
            3'b101:  alu_x = alu_a - alu_b;
            3'b110:  alu_x = alu_a + 8'd1;
            default: alu_x = alu_b + 8'd1;
        endcase
    end

    function automatic logic [15:0] f_alu(input logic [2:0] op, input logic [1:0] rd, ra, rb);
        return {2'b00, op, rd, ra, rb, 5'b0};
    endfunction
    function automatic logic [15:0] f_ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {2'b01, 4'b0, rd, imm};
    endfunction
    function automatic logic [15:0] f_out(input logic [1:0] ra);
        return {2'b10, 5'b0, ra, 7'b0};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        int n = 0;
        instr = w;
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
        if (!instr_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: instr_ready stayed 0 for instr %h", w);
        end
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic take_out(input string nm, input logic [7:0] exp);
        chk({nm, "_valid"}, res_valid, 1'b1);
        chk({nm, "_data"}, res_data, exp);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({nm, "_drop"}, res_valid, 1'b0);
    endtask

    typedef struct {
        string      name;
        logic [1:0] ra, rb, rd;
        logic [2:0] op;
        logic [7:0] a, b, exp;
    } vec_t;

    vec_t vt[9];

    initial begin
        int cyc;
        int acc;
        logic [7:0] bb [4];

        vt[0] = '{"add",   2'd0, 2'd1, 2'd2, 3'b100, 8'h05, 8'h03, 8'h08};
        vt[1] = '{"sub",   2'd0, 2'd1, 2'd3, 3'b101, 8'h03, 8'h05, 8'hFE};
        vt[2] = '{"inca",  2'd0, 2'd1, 2'd0, 3'b110, 8'hFF, 8'h00, 8'h00};
        vt[3] = '{"nota",  2'd0, 2'd1, 2'd1, 3'b011, 8'hA5, 8'h00, 8'h5A};
        vt[4] = '{"or",    2'd2, 2'd3, 2'd0, 3'b000, 8'hF0, 8'h0F, 8'hFF};
        vt[5] = '{"and",   2'd2, 2'd3, 2'd1, 3'b001, 8'hCC, 8'hAA, 8'h88};
        vt[6] = '{"xor",   2'd3, 2'd2, 2'd0, 3'b010, 8'hCC, 8'hAA, 8'h66};
        vt[7] = '{"incb",  2'd2, 2'd3, 2'd1, 3'b111, 8'h10, 8'h7F, 8'h80};
        vt[8] = '{"rd_ra", 2'd1, 2'd2, 2'd1, 3'b100, 8'h40, 8'h01, 8'h41};

        tick();
        tick();
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_data", res_data, 8'h00);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_op", alu_op, 3'b000);
`ifdef ALU_SEQUENCER_FLAGS_EN
        chk("rst_zero", zero, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        // Latency: ALU accept and res_valid of the following OUT are two cycles apart
        send(f_ldi(2'd0, 8'h05));
        send(f_ldi(2'd1, 8'h03));
        send(f_alu(3'b100, 2'd2, 2'd0, 2'd1));
        instr = f_out(2'd2);
        instr_valid = 1'b1;
        cyc = 0;
        while (!res_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        instr_valid = 1'b0;
        chk("lat_cycles", 16'(cyc), 16'd2);
        take_out("lat_out", 8'h08);

        for (int i = 0; i < 9; i++) begin
            send(f_ldi(vt[i].ra, vt[i].a));
            send(f_ldi(vt[i].rb, vt[i].b));
            send(f_alu(vt[i].op, vt[i].rd, vt[i].ra, vt[i].rb));
            chk({vt[i].name, "_alu_a"}, alu_a, vt[i].a);
            chk({vt[i].name, "_alu_b"}, alu_b, vt[i].b);
            chk({vt[i].name, "_alu_op"}, alu_op, vt[i].op);
            chk({vt[i].name, "_busy"}, instr_ready, 1'b0);
            send(f_out(vt[i].rd));
            take_out(vt[i].name, vt[i].exp);
        end
        chk("idle_alu_a", alu_a, 8'h00);

        // OUT backpressure for three cycles
        send(f_ldi(2'd2, 8'h3C));
        send(f_out(2'd2));
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", res_valid, 1'b1);
            chk("stall_data", res_data, 8'h3C);
            chk("stall_ready", instr_ready, 1'b0);
            tick();
        end
        take_out("stall_done", 8'h3C);
        chk("stall_idle", instr_ready, 1'b1);

        // Back-to-back LOADI, one per cycle
        bb[0] = 8'hA5; bb[1] = 8'h11; bb[2] = 8'h22; bb[3] = 8'h33;
        acc = 0;
        instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr = f_ldi(2'(k), bb[k]);
            if (instr_ready) acc++;
            tick();
        end
        instr_valid = 1'b0;
        chk("b2b_accepts", 16'(acc), 16'd4);
        for (int k = 0; k < 4; k++) begin
            send(f_out(2'(k)));
            take_out("b2b_out", bb[k]);
        end
        send(f_alu(3'b011, 2'd1, 2'd0, 2'd0));
        send(f_out(2'd1));
        take_out("b2b_not", 8'h5A);

`ifdef ALU_SEQUENCER_FLAGS_EN
        send(f_ldi(2'd1, 8'h00));
        send(f_ldi(2'd0, 8'hFF));
        send(f_alu(3'b110, 2'd0, 2'd0, 2'd0));
        send(f_out(2'd0));
        chk("zero_set", zero, 1'b1);
        take_out("zero_out", 8'h00);
        send(16'hE000);
        send(f_ldi(2'd1, 8'h77));
        send(f_out(2'd1));
        take_out("skip_out", 8'h00);
        send(f_ldi(2'd1, 8'h77));
        chk("zero_hold", zero, 1'b1);
        send(f_out(2'd1));
        take_out("noskip_out", 8'h77);
        send(f_alu(3'b100, 2'd2, 2'd1, 2'd1));
        send(f_out(2'd2));
        chk("zero_clr", zero, 1'b0);
        take_out("sum_out", 8'hEE);
        send(16'hE000);
        send(f_ldi(2'd3, 8'h33));
        send(f_out(2'd3));
        take_out("skipz_nz", 8'h33);
`endif

        // Reset while waiting in OUT_WAIT, with res_ready high during reset
        send(f_ldi(2'd0, 8'h11));
        send(f_out(2'd0));
        chk("pre_rst_valid", res_valid, 1'b1);
        rst_n = 1'b0;
        res_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        res_ready = 1'b0;
        chk("mid_rst_valid", res_valid, 1'b0);
        chk("mid_rst_ready", instr_ready, 1'b1);
        chk("mid_rst_data", res_data, 8'h00);
        for (int k = 0; k < 4; k++) begin
            send(f_out(2'(k)));
            take_out("rst_reg", 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
